// File: rtl/vjtag_dr_scan_master_if.sv
// Purpose: command/response handshake plus virtual-JTAG pins of the DR scan master.
// Latency: none, wiring only.
// Backpressure: cmd_valid/cmd_ready and rsp_valid/rsp_ready handshakes carried as-is.
interface vjtag_dr_scan_master_if #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_data;
  logic                vji_tck;
  logic                vji_tdi;
  logic                vji_tdo;
  logic [IR_WIDTH-1:0] vji_ir_in;
  logic                vji_uir;
  logic                vji_cdr;
  logic                vji_sdr;
  logic                vji_udr;
  logic                vji_rti;

  // Scan master side: takes commands, drives the virtual-JTAG pins, returns responses.
  modport master (
    input  cmd_valid, cmd_ir, cmd_data, rsp_ready, vji_tdo,
    output cmd_ready, rsp_valid, rsp_data,
    output vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
  );

  // Requester / debug-slave side.
  modport slave (
    output cmd_valid, cmd_ir, cmd_data, rsp_ready, vji_tdo,
    input  cmd_ready, rsp_valid, rsp_data,
    input  vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
  );
endinterface

// File: rtl/vjtag_dr_scan_master.sv
// Purpose: drives one {IR, DR} virtual-JTAG scan per command and returns the captured tdo word.
// Latency: accept to rsp_valid = (3+DR_WIDTH+RTI_CYCLES)*2*TCK_DIV clk cycles.
// Backpressure: one scan in flight; cmd_ready stays low until the response is taken.
module vjtag_dr_scan_master #(
  parameter int TCK_DIV    = 2,
  parameter int DR_WIDTH   = 38,
  parameter int IR_WIDTH   = 2,
  parameter int RTI_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  vjtag_dr_scan_master_if.master        bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RESP
  } state_t;

  localparam int CW   = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int MAXP = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
  localparam int PW   = $clog2(MAXP + 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       div_q, div_d;
  logic                tck_q, tck_d;
  logic [PW-1:0]       per_q, per_d;
  logic [DR_WIDTH-1:0] shift_q, shift_d;
  logic [DR_WIDTH-1:0] cap_q, cap_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                run, term, rise, fall;

  // tck only runs while a scan is in the JTAG states; IDLE/RESP park it low.
  assign run  = (state_q != S_IDLE) && (state_q != S_RESP);
  assign term = run && (div_q == CW'(TCK_DIV - 1));
  assign rise = term && !tck_q;
  assign fall = term && tck_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state, tck divider and scan datapath; every change of state lands on a fall event.
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    tck_d   = 1'b0;
    per_d   = per_q;
    shift_d = shift_q;
    cap_d   = cap_q;
    ir_d    = ir_q;
    if (run) begin
      div_d = term ? '0 : div_q + CW'(1);
      tck_d = term ? !tck_q : tck_q;
    end
    case (state_q)
      S_IDLE: if (bus.cmd_valid) begin
        state_d = S_UIR;
        ir_d    = bus.cmd_ir;
        shift_d = bus.cmd_data;
        per_d   = '0;
      end
      S_UIR: if (fall) state_d = S_CDR;
      S_CDR: if (fall) begin
        state_d = S_SDR;
        per_d   = '0;
      end
      S_SDR: begin
        if (rise) cap_d = {bus.vji_tdo, cap_q[DR_WIDTH-1:1]};
        if (fall) begin
          shift_d = shift_q >> 1;
          if (per_q == PW'(DR_WIDTH - 1)) begin
            state_d = S_UDR;
            per_d   = '0;
          end else begin
            per_d = per_q + PW'(1);
          end
        end
      end
      S_UDR: if (fall) begin
        state_d = S_RTI;
        per_d   = '0;
      end
      S_RTI: if (fall) begin
        if (per_q == PW'(RTI_CYCLES - 1)) state_d = S_RESP;
        else                              per_d   = per_q + PW'(1);
      end
      S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and divider registers; reset abandons any scan in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      tck_q   <= 1'b0;
      per_q   <= '0;
      shift_q <= '0;
      cap_q   <= '0;
      ir_q    <= '0;
    end else begin
      div_q   <= div_d;
      tck_q   <= tck_d;
      per_q   <= per_d;
      shift_q <= shift_d;
      cap_q   <= cap_d;
      ir_q    <= ir_d;
    end
  end

  // Strobes are a straight decode of the state so exactly one is high per JTAG state.
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_data  = cap_q;
  assign bus.vji_tck   = tck_q;
  assign bus.vji_tdi   = (state_q == S_SDR) ? shift_q[0] : 1'b0;
  assign bus.vji_ir_in = ir_q;
  assign bus.vji_uir   = (state_q == S_UIR);
  assign bus.vji_cdr   = (state_q == S_CDR);
  assign bus.vji_sdr   = (state_q == S_SDR);
  assign bus.vji_udr   = (state_q == S_UDR);
  assign bus.vji_rti   = (state_q == S_IDLE) || (state_q == S_RTI) || (state_q == S_RESP);

endmodule

// File: tb/tb_vjtag_dr_scan_master.sv
// Purpose: directed bench for vjtag_dr_scan_master (default timing plus a TCK_DIV=1 copy).
// Latency: expects rsp_valid 172 cycles after accept at the defaults, 86 with TCK_DIV=1.
// Backpressure: holds rsp_ready low to check response hold and command blocking.
module tb_vjtag_dr_scan_master;
  localparam int DW = 38;
  localparam int IW = 2;
  localparam int NV = 5;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  int   tdo_mode = 0;  // 0: tdo=tdi loopback, 1: tdo=0, 2: tdo=1

  vjtag_dr_scan_master_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) if0 ();
  vjtag_dr_scan_master_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) if1 ();

  vjtag_dr_scan_master #(.TCK_DIV(2), .DR_WIDTH(DW), .IR_WIDTH(IW), .RTI_CYCLES(2)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0.master)
  );
  vjtag_dr_scan_master #(.TCK_DIV(1), .DR_WIDTH(DW), .IR_WIDTH(IW), .RTI_CYCLES(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1.master)
  );

  always #5 clk = ~clk;

  assign if0.vji_tdo = (tdo_mode == 0) ? if0.vji_tdi : (tdo_mode == 2);
  assign if1.vji_tdo = 1'b0;

  typedef struct {
    logic [IW-1:0] ir;
    logic [DW-1:0] data;
    int            mode;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start0(input logic [IW-1:0] ir, input logic [DW-1:0] data);
    @(negedge clk);
    check("cmd_ready_before_accept", {63'd0, if0.cmd_ready}, 64'd1);
    if0.cmd_valid = 1'b1;
    if0.cmd_ir    = ir;
    if0.cmd_data  = data;
    @(posedge clk); #1;
    if0.cmd_valid = 1'b0;
  endtask

  // Called #1 after the accepting edge; returns edges counted until rsp_valid.
  task automatic wait_rsp0(input logic [IW-1:0] ir, input bit zero_data, output int lat);
    int       rises;
    int       viol;
    int       ns;
    bit       prev_tck;
    bit       ir_seen;
    logic [IW-1:0] ir_cap;
    rises = 0; viol = 0; prev_tck = 1'b0; ir_seen = 1'b0; ir_cap = '0;
    lat = 0;
    while (!if0.rsp_valid && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
      if (if0.vji_tck && !prev_tck && if0.vji_sdr) rises++;
      prev_tck = if0.vji_tck;
      if (if0.vji_uir && !ir_seen) begin
        ir_seen = 1'b1;
        ir_cap  = if0.vji_ir_in;
      end
      ns = int'(if0.vji_uir) + int'(if0.vji_cdr) + int'(if0.vji_sdr) + int'(if0.vji_udr);
      if (if0.vji_rti && ns != 0) viol++;
      if (!if0.vji_rti && ns != 1) viol++;
      if (!if0.vji_sdr && if0.vji_tdi) viol++;
      if (zero_data && if0.vji_tdi) viol++;
      if (if0.cmd_ready && !if0.rsp_valid) viol++;
    end
    check("rsp_valid_seen", {63'd0, if0.rsp_valid}, 64'd1);
    check("sdr_rise_count", 64'(rises), 64'd38);
    check("ir_in_at_uir", 64'(ir_cap), 64'(ir));
    check("strobe_tdi_ready_rules", 64'(viol), 64'd0);
  endtask

  function automatic int code1();
    int n;
    n = int'(if1.vji_uir) + int'(if1.vji_cdr) + int'(if1.vji_sdr) + int'(if1.vji_udr);
    if (n > 1 || (n == 1 && if1.vji_rti)) return 9;
    if (if1.vji_uir) return 1;
    if (if1.vji_cdr) return 2;
    if (if1.vji_sdr) return 3;
    if (if1.vji_udr) return 4;
    if (if1.vji_rti) return 5;
    return 0;
  endfunction

  initial begin
    int lat;
    int bad;
    int steps;
    int rises;
    int cur;
    int len;
    int c;
    int nruns;
    bit prev;
    int run_code [8];
    int run_len  [8];
    int exp_code [5];
    int exp_len  [5];
    logic [DW-1:0] held;

    vecs[0] = '{ir: 2'b01, data: 38'h2A_5A5A_A5A5, mode: 0, exp: 38'h2A_5A5A_A5A5};
    vecs[1] = '{ir: 2'b10, data: 38'h00_0000_0000, mode: 2, exp: 38'h3F_FFFF_FFFF};
    vecs[2] = '{ir: 2'b11, data: 38'h3F_FFFF_FFFF, mode: 1, exp: 38'h00_0000_0000};
    vecs[3] = '{ir: 2'b00, data: 38'h00_0000_0001, mode: 0, exp: 38'h00_0000_0001};
    vecs[4] = '{ir: 2'b10, data: 38'h20_0000_0000, mode: 0, exp: 38'h20_0000_0000};
    exp_code = '{1, 2, 3, 4, 5};
    exp_len  = '{2, 2, 76, 2, 4};

    if0.cmd_valid = 1'b0; if0.cmd_ir = '0; if0.cmd_data = '0; if0.rsp_ready = 1'b0;
    if1.cmd_valid = 1'b0; if1.cmd_ir = '0; if1.cmd_data = '0; if1.rsp_ready = 1'b1;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {63'd0, if0.cmd_ready}, 64'd1);
    check("rst_rsp_valid", {63'd0, if0.rsp_valid}, 64'd0);
    check("rst_rsp_data", 64'(if0.rsp_data), 64'd0);
    check("rst_tck", {63'd0, if0.vji_tck}, 64'd0);
    check("rst_tdi", {63'd0, if0.vji_tdi}, 64'd0);
    check("rst_ir_in", 64'(if0.vji_ir_in), 64'd0);
    check("rst_rti", {63'd0, if0.vji_rti}, 64'd1);
    check("rst_strobes", 64'({if0.vji_uir, if0.vji_cdr, if0.vji_sdr, if0.vji_udr}), 64'd0);
    reset_n = 1'b1;

    // Idle after reset: tck parked, ready, rti high, no strobes.
    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (if0.vji_tck || !if0.cmd_ready || !if0.vji_rti || if0.rsp_valid ||
          if0.vji_uir || if0.vji_cdr || if0.vji_sdr || if0.vji_udr) bad++;
    end
    check("idle_100_cycles", 64'(bad), 64'd0);

    // Table-driven scans with rsp_ready held high.
    if0.rsp_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      tdo_mode = vecs[i].mode;
      start0(vecs[i].ir, vecs[i].data);
      wait_rsp0(vecs[i].ir, (vecs[i].data == '0), lat);
      check($sformatf("latency_v%0d", i), 64'(lat), 64'd172);
      check($sformatf("rsp_data_v%0d", i), 64'(if0.rsp_data), 64'(vecs[i].exp));
      @(posedge clk); #1;
      check($sformatf("rsp_drop_v%0d", i), {63'd0, if0.rsp_valid}, 64'd0);
      check($sformatf("ready_back_v%0d", i), {63'd0, if0.cmd_ready}, 64'd1);
      check($sformatf("ir_hold_v%0d", i), 64'(if0.vji_ir_in), 64'(vecs[i].ir));
    end

    // Response backpressure: hold, ignore new command, accept only after handshake.
    tdo_mode = 0;
    if0.rsp_ready = 1'b0;
    start0(2'b11, 38'h12_3456_789A);
    wait_rsp0(2'b11, 1'b0, lat);
    check("bp_latency", 64'(lat), 64'd172);
    held = if0.rsp_data;
    check("bp_rsp_data", 64'(held), 64'h12_3456_789A);
    @(negedge clk);
    if0.cmd_valid = 1'b1; if0.cmd_ir = 2'b01; if0.cmd_data = 38'h0A_BCDE_F012;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (!if0.rsp_valid || if0.rsp_data !== held || if0.cmd_ready ||
          if0.vji_uir || if0.vji_tck) bad++;
    end
    check("bp_hold_20", 64'(bad), 64'd0);
    @(negedge clk);
    if0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rsp_released", {63'd0, if0.rsp_valid}, 64'd0);
    check("bp_ready_after_hs", {63'd0, if0.cmd_ready}, 64'd1);
    @(posedge clk); #1;
    if0.cmd_valid = 1'b0;
    check("bp_next_accepted", {63'd0, if0.cmd_ready}, 64'd0);
    check("bp_next_uir", {63'd0, if0.vji_uir}, 64'd1);
    wait_rsp0(2'b01, 1'b0, lat);
    check("bp_next_latency", 64'(lat), 64'd172);
    check("bp_next_data", 64'(if0.rsp_data), 64'h0A_BCDE_F012);
    @(posedge clk); #1;

    // Strobe order and durations on the TCK_DIV=1 instance.
    @(negedge clk);
    if1.cmd_valid = 1'b1; if1.cmd_ir = 2'b10; if1.cmd_data = 38'h15_5555_5555;
    @(posedge clk); #1;
    if1.cmd_valid = 1'b0;
    cur = code1(); len = 1; nruns = 0; steps = 0;
    while (steps < 500) begin
      @(posedge clk); #1;
      steps++;
      if (if1.rsp_valid) break;
      c = code1();
      if (c == cur) len++;
      else begin
        if (nruns < 8) begin run_code[nruns] = cur; run_len[nruns] = len; end
        nruns++;
        cur = c; len = 1;
      end
    end
    if (nruns < 8) begin run_code[nruns] = cur; run_len[nruns] = len; end
    nruns++;
    check("div1_latency", 64'(steps), 64'd86);
    check("div1_run_count", 64'(nruns), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < nruns && i < 8) begin
        check($sformatf("div1_run%0d_code", i), 64'(run_code[i]), 64'(exp_code[i]));
        check($sformatf("div1_run%0d_len", i), 64'(run_len[i]), 64'(exp_len[i]));
      end else begin
        check($sformatf("div1_run%0d_present", i), 64'(nruns), 64'(i + 1));
      end
    end
    check("div1_rsp_data", 64'(if1.rsp_data), 64'd0);
    @(posedge clk); #1;

    // Mid-scan reset during SDR bit 10.
    tdo_mode = 0;
    start0(2'b10, 38'h3C_0F0F_F0F0);
    rises = 0; prev = 1'b0; steps = 0;
    while (rises < 10 && steps < 1000) begin
      @(posedge clk); #1;
      steps++;
      if (if0.vji_tck && !prev && if0.vji_sdr) rises++;
      prev = if0.vji_tck;
    end
    check("mid_reached_bit10", 64'(rises), 64'd10);
    check("mid_in_sdr", {63'd0, if0.vji_sdr}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_cmd_ready", {63'd0, if0.cmd_ready}, 64'd1);
    check("mid_rsp_valid", {63'd0, if0.rsp_valid}, 64'd0);
    check("mid_rsp_data", 64'(if0.rsp_data), 64'd0);
    check("mid_tck", {63'd0, if0.vji_tck}, 64'd0);
    check("mid_tdi", {63'd0, if0.vji_tdi}, 64'd0);
    check("mid_ir_in", 64'(if0.vji_ir_in), 64'd0);
    check("mid_rti", {63'd0, if0.vji_rti}, 64'd1);
    check("mid_strobes", 64'({if0.vji_uir, if0.vji_cdr, if0.vji_sdr, if0.vji_udr}), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (if0.rsp_valid || if0.vji_tck || !if0.cmd_ready) bad++;
    end
    check("mid_no_late_rsp", 64'(bad), 64'd0);
    start0(2'b01, 38'h2A_5A5A_A5A5);
    wait_rsp0(2'b01, 1'b0, lat);
    check("post_reset_latency", 64'(lat), 64'd172);
    check("post_reset_data", 64'(if0.rsp_data), 64'h2A_5A5A_A5A5);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
